dac_write_arbiter: RTL and testbench

DAC_WRITE_ARBITER -- requirements
Module: dac_write_arbiter

---
 rtl/dac_arb_pkg.sv | 25 ++
 rtl/dac_write_arbiter_if.sv | 33 +++
 rtl/dac_arb_fifo.sv | 58 +++++
 rtl/dac_write_arbiter.sv | 107 ++++++++++
 tb/tb_dac_write_arbiter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dac_arb_pkg.sv
// Shared constants, payload types and sample conversion for the DAC write arbiter.
package dac_arb_pkg;

   localparam int         HOST_DEPTH = 4;
   localparam int         CHAN_W     = 2;
   localparam int         NUM_CHAN   = 1 << CHAN_W;
   localparam logic [5:0] VOL_FULL   = 6'h3F;

   typedef struct packed {
      logic [CHAN_W-1:0] chan;
      logic [7:0]        data;
   } host_entry_t;

   typedef struct packed {
      logic              vol;
      logic [CHAN_W-1:0] chan;
      logic [7:0]        data;
   } gs_entry_t;

   // Signed-style samples (bit7 clear) are folded into the unsigned DAC range.
   function automatic logic [7:0] conv_sample(input logic [7:0] d);
      return d[7] ? d : {1'b0, ~d[6:0]};
   endfunction

endpackage

// File: rtl/dac_write_arbiter_if.sv
// Host (Soundrive) and GS write ports plus the DAC/volume outputs of the arbiter.
interface dac_write_arbiter_if;
   import dac_arb_pkg::*;

   logic                         host_req;
   logic [CHAN_W-1:0]            host_chan;
   logic [7:0]                   host_data;
   logic                         host_full;
   logic                         host_ovf;
   logic                         ovf_clr;
   logic                         gs_req;
   logic                         gs_vol;
   logic [CHAN_W-1:0]            gs_chan;
   logic [7:0]                   gs_data;
   logic                         gs_busy;
   logic [NUM_CHAN*8-1:0]        dac_out;
   logic [NUM_CHAN*6-1:0]        vol_out;
   logic                         upd;
   logic [CHAN_W-1:0]            upd_chan;

   modport slave (
      input  host_req, host_chan, host_data, ovf_clr,
      input  gs_req, gs_vol, gs_chan, gs_data,
      output host_full, host_ovf, gs_busy, dac_out, vol_out, upd, upd_chan
   );

   modport master (
      output host_req, host_chan, host_data, ovf_clr,
      output gs_req, gs_vol, gs_chan, gs_data,
      input  host_full, host_ovf, gs_busy, dac_out, vol_out, upd, upd_chan
   );

endinterface

// File: rtl/dac_arb_fifo.sv
// Depth-parameterised host buffer; DEPTH=1 degenerates to a single holding register.
module dac_arb_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 10
) (
   input  logic             clk32,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_data  = r_mem[r_rd_ptr];

   // NOTE: storage has no reset; an empty count makes stale contents unreachable.
   always_ff @(posedge clk32) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   // NOTE: all state here uses <= so push and pop on one edge see the same old count.
   always_ff @(posedge clk32) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/dac_write_arbiter.sv
// Round-robin commit of host (Soundrive) and GS writes into four DAC/volume registers.
// Define DAC_HOST_FIFO_EN for a 4-deep host FIFO; otherwise the host buffer holds one entry.
module dac_write_arbiter
   import dac_arb_pkg::*;
(
   input logic                clk32,
   input logic                rst,
   dac_write_arbiter_if.slave bus
);

`ifdef DAC_HOST_FIFO_EN
   localparam int HOST_BUF_DEPTH = HOST_DEPTH;
`else
   localparam int HOST_BUF_DEPTH = 1;
`endif

   host_entry_t                  w_host_in;
   host_entry_t                  w_host_head;
   logic                         w_host_full;
   logic                         w_host_empty;
   logic                         w_host_push;
   logic                         w_grant_host;
   logic                         w_grant_gs;
   logic                         w_gs_accept;

   gs_entry_t                    r_gs;
   logic                         r_gs_busy;
   logic                         r_last_gs;
   logic                         r_host_ovf;
   logic                         r_upd;
   logic [CHAN_W-1:0]            r_upd_chan;
   logic [NUM_CHAN-1:0][7:0]     r_dac;
   logic [NUM_CHAN-1:0][5:0]     r_vol;

   assign w_host_in   = '{chan: bus.host_chan, data: bus.host_data};
   assign w_host_push = bus.host_req & ~w_host_full;
   assign w_gs_accept = bus.gs_req & ~r_gs_busy;

   dac_arb_fifo #(
      .DEPTH (HOST_BUF_DEPTH),
      .WIDTH ($bits(host_entry_t))
   ) u_host_buf (
      .clk32   (clk32),
      .rst     (rst),
      .i_push  (w_host_push),
      .i_data  (w_host_in),
      .i_pop   (w_grant_host),
      .o_data  (w_host_head),
      .o_full  (w_host_full),
      .o_empty (w_host_empty)
   );

   // r_last_gs set means GS won the previous grant, so host is favoured next.
   assign w_grant_host = ~w_host_empty & (~r_gs_busy | r_last_gs);
   assign w_grant_gs   = r_gs_busy & ~w_grant_host;

   always_ff @(posedge clk32) begin
      if (rst) begin
         r_gs      <= '0;
         r_gs_busy <= 1'b0;
      end else if (w_grant_gs) begin
         r_gs_busy <= 1'b0;
      end else if (w_gs_accept) begin
         r_gs      <= '{vol: bus.gs_vol, chan: bus.gs_chan, data: bus.gs_data};
         r_gs_busy <= 1'b1;
      end
   end

   // A rejected request outranks a simultaneous clear.
   always_ff @(posedge clk32) begin
      if (rst)                              r_host_ovf <= 1'b0;
      else if (bus.host_req && w_host_full) r_host_ovf <= 1'b1;
      else if (bus.ovf_clr)                 r_host_ovf <= 1'b0;
   end

   always_ff @(posedge clk32) begin
      if (rst) begin
         r_dac      <= '0;
         r_vol      <= '0;
         r_upd      <= 1'b0;
         r_upd_chan <= '0;
         r_last_gs  <= 1'b1;
      end else begin
         r_upd <= w_grant_host | w_grant_gs;
         if (w_grant_host) begin
            r_dac[w_host_head.chan] <= conv_sample(w_host_head.data);
            r_vol[w_host_head.chan] <= VOL_FULL;
            r_upd_chan              <= w_host_head.chan;
            r_last_gs               <= 1'b0;
         end else if (w_grant_gs) begin
            if (r_gs.vol) r_vol[r_gs.chan] <= r_gs.data[5:0];
            else          r_dac[r_gs.chan] <= conv_sample(r_gs.data);
            r_upd_chan <= r_gs.chan;
            r_last_gs  <= 1'b1;
         end
      end
   end

   assign bus.host_full = w_host_full;
   assign bus.host_ovf  = r_host_ovf;
   assign bus.gs_busy   = r_gs_busy;
   assign bus.dac_out   = r_dac;
   assign bus.vol_out   = r_vol;
   assign bus.upd       = r_upd;
   assign bus.upd_chan  = r_upd_chan;

endmodule

// File: tb/tb_dac_write_arbiter.sv
// Directed bench for dac_write_arbiter: vector table plus hand-written corner sequences.
module tb_dac_write_arbiter;

   logic clk32 = 1'b0;
   logic rst;

   dac_write_arbiter_if bus();

   dac_write_arbiter dut (
      .clk32 (clk32),
      .rst   (rst),
      .bus   (bus)
   );

   always #5 clk32 = ~clk32;

`ifdef DAC_HOST_FIFO_EN
   localparam logic FULL_AFTER_ONE = 1'b0;
`else
   localparam logic FULL_AFTER_ONE = 1'b1;
`endif

   typedef struct {
      logic        is_gs;
      logic        is_vol;
      logic [1:0]  chan;
      logic [7:0]  data;
      logic [31:0] exp_dac;
      logic [23:0] exp_vol;
   } vec_t;

   vec_t       vecs [9];
   logic [7:0] exp_q [$];
   int         n_checks = 0;
   int         n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] model_conv(input logic [7:0] d);
      if (d[7]) return d;
      return 8'h7F & ~d;
   endfunction

   task automatic tick();
      @(posedge clk32);
      #1;
   endtask

   task automatic idle_inputs();
      bus.host_req  = 1'b0;
      bus.host_chan = 2'd0;
      bus.host_data = 8'h00;
      bus.ovf_clr   = 1'b0;
      bus.gs_req    = 1'b0;
      bus.gs_vol    = 1'b0;
      bus.gs_chan   = 2'd0;
      bus.gs_data   = 8'h00;
   endtask

   task automatic watch_host_commit();
      if (bus.upd && bus.upd_chan == 2'd0) begin
         check("burst_commit_expected", exp_q.size() > 0, 1'b1);
         if (exp_q.size() > 0) check("burst_fifo_order", bus.dac_out[7:0], model_conv(exp_q.pop_front()));
      end
   endtask

   // Hold host_req (chan 0) with GS volume traffic on chan 3 until one request is rejected.
   task automatic overflow_burst(input logic with_clr);
      logic       rejected;
      logic [7:0] d;
      rejected = 1'b0;
      d        = 8'h90;
      exp_q.delete();
      bus.gs_req  = 1'b1;
      bus.gs_vol  = 1'b1;
      bus.gs_chan = 2'd3;
      bus.gs_data = 8'h0A;
      for (int i = 0; i < 40 && !rejected; i++) begin
         bus.host_req  = 1'b1;
         bus.host_chan = 2'd0;
         bus.host_data = d;
         if (bus.host_full) begin
            rejected    = 1'b1;
            bus.ovf_clr = with_clr;
         end else begin
            exp_q.push_back(d);
         end
         tick();
         watch_host_commit();
         d++;
      end
      idle_inputs();
      check("burst_reject_reached", rejected, 1'b1);
      check(with_clr ? "ovf_set_wins_over_clr" : "ovf_set_on_reject", bus.host_ovf, 1'b1);
      for (int i = 0; i < 30; i++) begin
         tick();
         watch_host_commit();
      end
      check("burst_all_committed", exp_q.size(), 0);
      check("burst_full_after_drain", bus.host_full, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic any_upd;

      vecs[0] = '{1'b0, 1'b0, 2'd2, 8'h10, 32'h006F_0000, 24'h03F000};
      vecs[1] = '{1'b1, 1'b1, 2'd1, 8'h25, 32'h006F_0000, 24'h03F940};
      vecs[2] = '{1'b0, 1'b0, 2'd0, 8'h7F, 32'h006F_0000, 24'h03F97F};
      vecs[3] = '{1'b0, 1'b0, 2'd3, 8'h00, 32'h7F6F_0000, 24'hFFF97F};
      vecs[4] = '{1'b0, 1'b0, 2'd1, 8'hFF, 32'h7F6F_FF00, 24'hFFFFFF};
      vecs[5] = '{1'b1, 1'b0, 2'd0, 8'h05, 32'h7F6F_FF7A, 24'hFFFFFF};
      vecs[6] = '{1'b1, 1'b0, 2'd2, 8'h01, 32'h7F7E_FF7A, 24'hFFFFFF};
      vecs[7] = '{1'b0, 1'b0, 2'd3, 8'h81, 32'h817E_FF7A, 24'hFFFFFF};
      vecs[8] = '{1'b1, 1'b1, 2'd3, 8'hC5, 32'h817E_FF7A, 24'h17FFFF};

      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      check("rst_dac_out",   bus.dac_out,   32'h0);
      check("rst_vol_out",   bus.vol_out,   24'h0);
      check("rst_host_full", bus.host_full, 1'b0);
      check("rst_host_ovf",  bus.host_ovf,  1'b0);
      check("rst_gs_busy",   bus.gs_busy,   1'b0);
      check("rst_upd",       bus.upd,       1'b0);
      check("rst_upd_chan",  bus.upd_chan,  2'd0);
      rst = 1'b0;
      tick();

      // Single-source writes: capture edge, commit edge, then upd must drop.
      for (int i = 0; i < 9; i++) begin
         if (vecs[i].is_gs) begin
            bus.gs_req  = 1'b1;
            bus.gs_vol  = vecs[i].is_vol;
            bus.gs_chan = vecs[i].chan;
            bus.gs_data = vecs[i].data;
         end else begin
            bus.host_req  = 1'b1;
            bus.host_chan = vecs[i].chan;
            bus.host_data = vecs[i].data;
         end
         tick();
         idle_inputs();
         check($sformatf("v%0d_capture_upd", i), bus.upd, 1'b0);
         check($sformatf("v%0d_capture_gs_busy", i), bus.gs_busy, vecs[i].is_gs);
         check($sformatf("v%0d_capture_host_full", i), bus.host_full,
               vecs[i].is_gs ? 1'b0 : FULL_AFTER_ONE);
         tick();
         check($sformatf("v%0d_commit_upd", i), bus.upd, 1'b1);
         check($sformatf("v%0d_commit_upd_chan", i), bus.upd_chan, vecs[i].chan);
         check($sformatf("v%0d_commit_dac", i), bus.dac_out, vecs[i].exp_dac);
         check($sformatf("v%0d_commit_vol", i), bus.vol_out, vecs[i].exp_vol);
         check($sformatf("v%0d_commit_gs_busy", i), bus.gs_busy, 1'b0);
         tick();
         check($sformatf("v%0d_upd_one_cycle", i), bus.upd, 1'b0);
         check($sformatf("v%0d_upd_chan_hold", i), bus.upd_chan, vecs[i].chan);
      end

      // Host and GS to channel 0 on one edge; GS won last, so host commits first.
      bus.host_req  = 1'b1;
      bus.host_chan = 2'd0;
      bus.host_data = 8'h80;
      bus.gs_req    = 1'b1;
      bus.gs_vol    = 1'b0;
      bus.gs_chan   = 2'd0;
      bus.gs_data   = 8'hC0;
      tick();
      idle_inputs();
      check("rr_capture_gs_busy", bus.gs_busy, 1'b1);
      tick();
      check("rr_host_first_upd", bus.upd, 1'b1);
      check("rr_host_first_dac", bus.dac_out, 32'h817E_FF80);
      check("rr_gs_still_busy", bus.gs_busy, 1'b1);
      tick();
      check("rr_gs_next_upd", bus.upd, 1'b1);
      check("rr_gs_next_dac", bus.dac_out, 32'h817E_FFC0);
      check("rr_gs_next_vol", bus.vol_out, 24'h17FFFF);
      check("rr_gs_busy_clear", bus.gs_busy, 1'b0);
      tick();
      check("rr_upd_drop", bus.upd, 1'b0);

      // Overflow, clear alone, then clear coinciding with a rejected request.
      overflow_burst(1'b0);
      bus.ovf_clr = 1'b1;
      tick();
      bus.ovf_clr = 1'b0;
      check("ovf_clr_alone", bus.host_ovf, 1'b0);
      overflow_burst(1'b1);
      check("ovf_sticky_before_reset", bus.host_ovf, 1'b1);

      // Reset with host (and GS) entries pending must discard everything.
      bus.gs_req    = 1'b1;
      bus.gs_chan   = 2'd1;
      bus.gs_data   = 8'h22;
      bus.host_req  = 1'b1;
      bus.host_chan = 2'd2;
      for (int i = 0; i < 3; i++) begin
         bus.host_data = 8'h11 + 8'(i);
         tick();
         bus.gs_req = 1'b0;
      end
      idle_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_dac_out",   bus.dac_out,   32'h0);
      check("mid_rst_vol_out",   bus.vol_out,   24'h0);
      check("mid_rst_host_full", bus.host_full, 1'b0);
      check("mid_rst_host_ovf",  bus.host_ovf,  1'b0);
      check("mid_rst_gs_busy",   bus.gs_busy,   1'b0);
      check("mid_rst_upd_chan",  bus.upd_chan,  2'd0);
      any_upd = 1'b0;
      for (int i = 0; i < 6; i++) begin
         any_upd = any_upd | bus.upd;
         tick();
      end
      check("mid_rst_no_upd", any_upd, 1'b0);
      check("mid_rst_dac_stays", bus.dac_out, 32'h0);

      // After reset the pointer favours host.
      bus.host_req  = 1'b1;
      bus.host_chan = 2'd1;
      bus.host_data = 8'h01;
      bus.gs_req    = 1'b1;
      bus.gs_vol    = 1'b0;
      bus.gs_chan   = 2'd2;
      bus.gs_data   = 8'h02;
      tick();
      idle_inputs();
      check("post_rst_host_full", bus.host_full, FULL_AFTER_ONE);
      tick();
      check("post_rst_host_first_chan", bus.upd_chan, 2'd1);
      check("post_rst_host_first_dac", bus.dac_out, 32'h0000_7E00);
      check("post_rst_host_first_vol", bus.vol_out, 24'h000FC0);
      tick();
      check("post_rst_gs_chan", bus.upd_chan, 2'd2);
      check("post_rst_gs_dac", bus.dac_out, 32'h007D_7E00);
      tick();
      check("post_rst_upd_drop", bus.upd, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
